// File: rtl/fb_arbiter.sv
// Framebuffer BRAM arbiter: display scanout reads have absolute priority, and
// renderer writes take every other cycle through a valid/ready handshake.
module fb_arbiter #(
    parameter int FB_W        = 256,
    parameter int FB_H        = 192,
    parameter int SCALE_SHIFT = 2,
    parameter int PIX_W       = 12,
    parameter int ADDR_W      = 16
) (
    input  logic              clk_75MHz,
    input  logic              rst_n,
    input  logic [9:0]        h_pixel,
    input  logic [9:0]        v_pixel,
    input  logic              in_disp_area,
    output logic [PIX_W-1:0]  pixel_data,
    input  logic              rt_wr_valid,
    output logic              rt_wr_ready,
    input  logic [7:0]        rt_wr_x,
    input  logic [7:0]        rt_wr_y,
    input  logic [PIX_W-1:0]  rt_wr_data,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_we,
    output logic [PIX_W-1:0]  fb_wdata,
    input  logic [PIX_W-1:0]  fb_rdata,
    output logic [15:0]       rt_stall_cnt
);

    localparam int X_W = $clog2(FB_W);
    localparam int Y_W = ADDR_W - X_W;
    localparam logic [9:0]     LAST_LINE = 10'(FB_H * (1 << SCALE_SHIFT) - 1);
    localparam logic [8:0]     FB_H_LIM  = 9'(FB_H);
    localparam logic [X_W-1:0] LAST_COL  = X_W'(FB_W - 1);

    localparam logic [2:0] S_BLANK   = 3'd0;
    localparam logic [2:0] S_PRE     = 3'd1;
    localparam logic [2:0] S_PRE_CAP = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_ACTIVE  = 3'd4;

    logic [2:0]        state;
    logic              disp_q;
    logic [9:0]        v_q;
    logic [PIX_W-1:0]  stage;

    logic              line_end;
    logic              line_start;
    logic [1:0]        phase;
    logic [X_W-1:0]    col;
    logic [X_W-1:0]    col_next;
    logic              last_col;
    logic [Y_W-1:0]    row;
    logic [Y_W-1:0]    v_q_row;
    logic [Y_W-1:0]    next_row;
    logic              active_rd;
    logic              pre_rd;
    logic              disp_slot;
    logic              wr_fire;
    logic [ADDR_W-1:0] rd_addr;

    assign line_end   = disp_q & ~in_disp_area;
    assign line_start = in_disp_area & ~disp_q;
    assign phase      = h_pixel[1:0];
    assign col        = h_pixel[SCALE_SHIFT +: X_W];
    assign col_next   = col + X_W'(1);
    assign last_col   = (col == LAST_COL);
    assign row        = v_pixel[SCALE_SHIFT +: Y_W];
    assign v_q_row    = v_q[SCALE_SHIFT +: Y_W];

    // (v_q + 1) >> SCALE_SHIFT, written so every bit of v_q is used directly.
    assign next_row = (v_q == LAST_LINE) ? '0
                    : v_q_row + Y_W'(&v_q[SCALE_SHIFT-1:0]);

    assign active_rd   = (state == S_ACTIVE) && (phase == 2'b01) && !last_col;
    assign pre_rd      = (state == S_PRE);
    assign disp_slot   = active_rd | pre_rd;
    assign rt_wr_ready = rst_n & ~disp_slot;
    assign wr_fire     = rt_wr_valid & rt_wr_ready & ({1'b0, rt_wr_y} < FB_H_LIM);

    always_comb begin
        rd_addr = '0;
        if (pre_rd)
            rd_addr = {next_row, {X_W{1'b0}}};
        else
            rd_addr = {row, col_next};
    end

    always_ff @(posedge clk_75MHz or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_BLANK;
            disp_q <= 1'b0;
            v_q    <= '0;
        end else begin
            disp_q <= in_disp_area;
            if (in_disp_area)
                v_q <= v_pixel;
            case (state)
                S_BLANK:   if (line_end) state <= S_PRE;
                S_PRE:     state <= S_PRE_CAP;
                S_PRE_CAP: state <= S_WAIT;
                S_WAIT:    if (line_start) state <= S_ACTIVE;
                S_ACTIVE:  if (line_end) state <= S_PRE;
                default:   state <= S_BLANK;
            endcase
        end
    end

    // Prefetch one column ahead so the new pixel lands on the h_pixel[1:0]==00 boundary.
    always_ff @(posedge clk_75MHz or negedge rst_n) begin
        if (!rst_n) begin
            stage      <= '0;
            pixel_data <= '0;
        end else if (state == S_PRE_CAP) begin
            stage      <= fb_rdata;
            pixel_data <= fb_rdata;
        end else if (state == S_ACTIVE && !last_col) begin
            if (phase == 2'b10)
                stage <= fb_rdata;
            else if (phase == 2'b11)
                pixel_data <= stage;
        end
    end

    always_ff @(posedge clk_75MHz or negedge rst_n) begin
        if (!rst_n) begin
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= '0;
        end else begin
            fb_we <= wr_fire;
            if (wr_fire) begin
                fb_addr  <= {rt_wr_y, rt_wr_x};
                fb_wdata <= rt_wr_data;
            end else if (disp_slot) begin
                fb_addr <= rd_addr;
            end
        end
    end

    always_ff @(posedge clk_75MHz or negedge rst_n) begin
        if (!rst_n)
            rt_stall_cnt <= '0;
        else if (rt_wr_valid && !rt_wr_ready && rt_stall_cnt != 16'hFFFF)
            rt_stall_cnt <= rt_stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: scanout lines against a preloaded framebuffer,
// ready/stall accounting, write path, dropped writes, reset and stall saturation.
module tb_fb_arbiter;

    localparam int H_TOTAL = 1032;

    logic        clk_75MHz = 1'b0;
    logic        rst_n;
    logic [9:0]  h_pixel;
    logic [9:0]  v_pixel;
    logic        in_disp_area;
    logic [11:0] pixel_data;
    logic        rt_wr_valid;
    logic        rt_wr_ready;
    logic [7:0]  rt_wr_x;
    logic [7:0]  rt_wr_y;
    logic [11:0] rt_wr_data;
    logic [15:0] fb_addr;
    logic        fb_we;
    logic [11:0] fb_wdata;
    logic [11:0] fb_rdata;
    logic [15:0] rt_stall_cnt;

    logic [11:0] mem [0:65535];

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          n_fail    = 0;
    int          stall_exp = 0;
    bit          wrote_abc = 1'b0;
    logic [11:0] probe_pix = '0;

    always #5 clk_75MHz = ~clk_75MHz;

    fb_arbiter dut (
        .clk_75MHz    (clk_75MHz),
        .rst_n        (rst_n),
        .h_pixel      (h_pixel),
        .v_pixel      (v_pixel),
        .in_disp_area (in_disp_area),
        .pixel_data   (pixel_data),
        .rt_wr_valid  (rt_wr_valid),
        .rt_wr_ready  (rt_wr_ready),
        .rt_wr_x      (rt_wr_x),
        .rt_wr_y      (rt_wr_y),
        .rt_wr_data   (rt_wr_data),
        .fb_addr      (fb_addr),
        .fb_we        (fb_we),
        .fb_wdata     (fb_wdata),
        .fb_rdata     (fb_rdata),
        .rt_stall_cnt (rt_stall_cnt)
    );

    // BRAM model: data for a registered address is available during the following cycle.
    always @(posedge clk_75MHz)
        if (fb_we) mem[fb_addr] <= fb_wdata;
    assign fb_rdata = mem[fb_addr];

    function automatic logic [11:0] exp_value(input int col, input int row);
        if (wrote_abc && col == 5 && row == 7) return 12'hABC;
        return 12'((row << 8) | col);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int h, input int v, input logic disp);
        @(negedge clk_75MHz);
        h_pixel      = 10'(h);
        v_pixel      = 10'(v);
        in_disp_area = disp;
        #1;
    endtask

    task automatic run_line(input int v, input bit active);
        int          bad_pix  = 0;
        int          bad_rdy  = 0;
        int          we_cnt   = 0;
        int          first_h  = -1;
        logic [11:0] got_pix  = '0;
        logic [11:0] want_pix = '0;
        logic [11:0] want;
        logic        want_rdy;
        for (int h = 0; h < H_TOTAL; h++) begin
            apply_stimulus(h, v, h < 1024);
            want_rdy = !((active && h < 1024 && (h % 4) == 1 && (h / 4) != 255) || h == 1025);
            if (rt_wr_ready !== want_rdy) bad_rdy++;
            if (rt_wr_valid && !want_rdy) stall_exp++;
            if (fb_we !== 1'b0) we_cnt++;
            if (h < 1024) begin
                want = active ? exp_value(h / 4, v / 4) : 12'h000;
                if (h == 22) probe_pix = pixel_data;
                if (pixel_data !== want) begin
                    if (bad_pix == 0) begin
                        first_h  = h;
                        got_pix  = pixel_data;
                        want_pix = want;
                    end
                    bad_pix++;
                end
            end
        end
        check_output($sformatf("pixels v=%0d (first bad h=%0d got 0x%0h want 0x%0h)",
                               v, first_h, got_pix, want_pix), bad_pix, 0);
        check_output($sformatf("ready_pattern v=%0d", v), bad_rdy, 0);
        check_output($sformatf("dropped_we v=%0d", v), we_cnt, 0);
        check_output($sformatf("stall_cnt v=%0d", v), rt_stall_cnt, stall_exp);
    endtask

    initial begin
        int k;
        rst_n        = 1'b0;
        h_pixel      = '0;
        v_pixel      = '0;
        in_disp_area = 1'b0;
        rt_wr_valid  = 1'b0;
        rt_wr_x      = '0;
        rt_wr_y      = '0;
        rt_wr_data   = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 12'(a);

        // Power-on reset.
        repeat (3) @(negedge clk_75MHz);
        #1;
        check_output("por_ready", rt_wr_ready, 0);
        check_output("por_pixel", pixel_data, 0);
        check_output("por_we", fb_we, 0);
        check_output("por_addr", fb_addr, 0);
        check_output("por_stall", rt_stall_cnt, 0);
        rst_n = 1'b1;
        #1;
        check_output("ready_after_reset", rt_wr_ready, 1);

        // Out-of-range stream: accepted but never written.
        rt_wr_valid = 1'b1;
        rt_wr_x     = 8'd9;
        rt_wr_y     = 8'd200;
        rt_wr_data  = 12'h123;
        apply_stimulus(1031, 26, 1'b0);
        check_output("oor_ready", rt_wr_ready, 1);
        apply_stimulus(1031, 26, 1'b0);
        check_output("oor_we", fb_we, 0);
        check_output("oor_addr_hold", fb_addr, 0);

        run_line(26, 1'b0);
        run_line(27, 1'b1);

        // Single in-range write during blanking.
        rt_wr_x    = 8'd5;
        rt_wr_y    = 8'd7;
        rt_wr_data = 12'hABC;
        check_output("wr_ready", rt_wr_ready, 1);
        apply_stimulus(1031, 27, 1'b0);
        check_output("wr_we", fb_we, 1);
        check_output("wr_addr", fb_addr, 16'h0705);
        check_output("wr_data", fb_wdata, 12'hABC);
        rt_wr_x = 8'd9;
        rt_wr_y = 8'd200;
        apply_stimulus(1031, 27, 1'b0);
        check_output("wr_we_clear", fb_we, 0);
        check_output("wr_addr_hold", fb_addr, 16'h0705);
        wrote_abc = 1'b1;

        run_line(28, 1'b1);
        check_output("written_pixel_v28_h22", probe_pix, 12'hABC);
        run_line(31, 1'b1);

        // Reset mid-line with a write in flight.
        for (int h = 0; h < 5; h++) apply_stimulus(h, 100, 1'b1);
        rt_wr_x    = 8'd0;
        rt_wr_y    = 8'd0;
        rt_wr_data = 12'h5A5;
        check_output("midline_wr_ready", rt_wr_ready, 1);
        apply_stimulus(5, 100, 1'b1);
        check_output("inflight_we", fb_we, 1);
        check_output("inflight_wdata", fb_wdata, 12'h5A5);
        rst_n = 1'b0;
        #1;
        check_output("rst_pixel", pixel_data, 0);
        check_output("rst_we", fb_we, 0);
        check_output("rst_addr", fb_addr, 0);
        check_output("rst_wdata", fb_wdata, 0);
        check_output("rst_stall", rt_stall_cnt, 0);
        check_output("rst_ready", rt_wr_ready, 0);
        rt_wr_x = 8'd9;
        rt_wr_y = 8'd200;
        apply_stimulus(1024, 100, 1'b0);
        apply_stimulus(1025, 100, 1'b0);
        rst_n = 1'b1;
        stall_exp = 0;
        #1;
        check_output("ready_after_midline_reset", rt_wr_ready, 1);

        // First line after reset stays black; then row wrap 767 -> 0.
        run_line(767, 1'b0);
        run_line(0, 1'b1);

        // Saturation: park on a display read slot so every cycle stalls.
        apply_stimulus(0, 1, 1'b1);
        apply_stimulus(1, 1, 1'b1);
        check_output("sat_slot_ready", rt_wr_ready, 0);
        k = 65534 - stall_exp;
        repeat (k) @(negedge clk_75MHz);
        #1;
        check_output("stall_65534", rt_stall_cnt, 16'hFFFE);
        @(negedge clk_75MHz);
        #1;
        check_output("stall_saturate", rt_stall_cnt, 16'hFFFF);
        repeat (20) @(negedge clk_75MHz);
        #1;
        check_output("stall_no_wrap", rt_stall_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
